// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the clock-divider configuration controller.
package clk_div_ctrl_pkg;

   localparam int STATE_W        = 3;
   localparam int DEF_GUARD_CYC  = 4;
   localparam int DEF_SETTLE_CYC = 8;
   localparam int DEF_DIV_RATIO  = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      GATE   = 3'd1,
      LOAD   = 3'd2,
      SETTLE = 3'd3,
      ACK    = 3'd4
   } state_t;

   // Larger of two integers; sizes the shared guard/settle counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest requesting index at or
// above rr_ptr, wrapping around, and reports it one-hot and as an index.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       valid
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW:0]   sum_next;
   logic [IW-1:0] cand_next;

   // Walk the candidates starting at rr_ptr; the first requester found wins.
   always_comb begin
      grant     = '0;
      gnt_idx   = '0;
      valid     = 1'b0;
      sum_next  = '0;
      cand_next = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum_next = {1'b0, rr_ptr} + (IW+1)'(i);
         if (sum_next >= (IW+1)'(NUM_REQ)) begin
            sum_next = sum_next - (IW+1)'(NUM_REQ);
         end
         cand_next = sum_next[IW-1:0];
         if (!valid && req[cand_next]) begin
            valid            = 1'b1;
            gnt_idx          = cand_next;
            grant[cand_next] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Arbitrates ratio requests for one shared clock divider: gates CLK_EN, loads
// the winner's ratio, re-enables, waits a settle window, then acks.
// Optional feature macro: CLK_DIV_SKIP_SAME_RATIO_EN -- when the winner asks
// for the ratio already driven, the gate/load/settle sequence is skipped.
module clk_div_cfg_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int RATIO_W    = 8,
   parameter int DEF_RATIO  = DEF_DIV_RATIO,
   parameter int GUARD_CYC  = DEF_GUARD_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic                         I_REF_CLK,
   input  logic                         RST_EN,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*RATIO_W-1:0]   req_ratio,
   output logic [NUM_REQ-1:0]           ack,
   output logic [$clog2(NUM_REQ)-1:0]   gnt_id,
   output logic                         busy,
   output logic                         CLK_EN,
   output logic [RATIO_W-1:0]           DIV_RATIO
);

   localparam int IW      = $clog2(NUM_REQ);
   localparam int MAX_CYC = max_int(GUARD_CYC, SETTLE_CYC);
   localparam int CW      = $clog2(MAX_CYC) + 1;

   state_t               state_reg;
   logic [CW-1:0]        cnt_reg;
   logic [IW-1:0]        rr_ptr_reg;
   logic [IW-1:0]        gnt_id_reg;
   logic [NUM_REQ-1:0]   gnt_oh_reg;
   logic [RATIO_W-1:0]   ratio_reg;
   logic [RATIO_W-1:0]   div_ratio_reg;
   logic                 clk_en_reg;
   logic [NUM_REQ-1:0]   ack_reg;

   logic [NUM_REQ-1:0]   win_oh;
   logic [IW-1:0]        win_idx;
   logic                 win_valid;
   logic [RATIO_W-1:0]   ratio_arr [NUM_REQ];
   logic [RATIO_W-1:0]   win_ratio;

   // Unpack the flat ratio bus so the winner's slice can be selected by index.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ratio
      assign ratio_arr[gi] = req_ratio[gi*RATIO_W +: RATIO_W];
   end

   assign win_ratio = ratio_arr[win_idx];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req     (req),
      .rr_ptr  (rr_ptr_reg),
      .grant   (win_oh),
      .gnt_idx (win_idx),
      .valid   (win_valid)
   );

   // Reconfiguration sequencer; every output it drives is registered.
   always_ff @(posedge I_REF_CLK) begin
      if (RST_EN) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         rr_ptr_reg    <= '0;
         gnt_id_reg    <= '0;
         gnt_oh_reg    <= '0;
         ratio_reg     <= RATIO_W'(DEF_RATIO);
         div_ratio_reg <= RATIO_W'(DEF_RATIO);
         clk_en_reg    <= 1'b1;
         ack_reg       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_valid) begin
                  gnt_id_reg <= win_idx;
                  gnt_oh_reg <= win_oh;
                  ratio_reg  <= win_ratio;
                  cnt_reg    <= '0;
`ifdef CLK_DIV_SKIP_SAME_RATIO_EN
                  if (win_ratio == div_ratio_reg) begin
                     ack_reg   <= win_oh;
                     state_reg <= ACK;
                  end else begin
                     clk_en_reg <= 1'b0;
                     state_reg  <= GATE;
                  end
`else
                  clk_en_reg <= 1'b0;
                  state_reg  <= GATE;
`endif
               end
            end
            GATE: begin
               if (cnt_reg == CW'(GUARD_CYC - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= LOAD;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            LOAD: begin
               div_ratio_reg <= ratio_reg;
               clk_en_reg    <= 1'b1;
               cnt_reg       <= '0;
               state_reg     <= SETTLE;
            end
            SETTLE: begin
               if (cnt_reg == CW'(SETTLE_CYC - 1)) begin
                  cnt_reg   <= '0;
                  ack_reg   <= gnt_oh_reg;
                  state_reg <= ACK;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ACK: begin
               if (!req[gnt_id_reg]) begin
                  ack_reg    <= '0;
                  rr_ptr_reg <= (gnt_id_reg == IW'(NUM_REQ - 1)) ? '0 : gnt_id_reg + 1'b1;
                  state_reg  <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_reg;
   assign gnt_id    = gnt_id_reg;
   assign busy      = (state_reg != IDLE);
   assign CLK_EN    = clk_en_reg;
   assign DIV_RATIO = div_ratio_reg;

endmodule
